// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - opcode/memory handshake and datapath control bundle for mc_control
interface mc_control_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                memread;
  logic                memwrite;
  logic                ir_write;
  logic                memtoreg;
  logic                regdst;
  logic                regwrite;
  logic                alusrc_a;
  logic [1:0]          alusrc_b;
  logic [1:0]          aluop;
  logic [1:0]          pc_source;
  logic                bus_err;
  logic                illegal;
  logic [3:0]          state;

  // Controller side: consumes opcode/mem_ready, drives datapath controls
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, memread, memwrite, ir_write,
           memtoreg, regdst, regwrite, alusrc_a, alusrc_b, aluop,
           pc_source, bus_err, illegal, state
  );

  // Datapath/memory side
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, memread, memwrite, ir_write,
           memtoreg, regdst, regwrite, alusrc_a, alusrc_b, aluop,
           pc_source, bus_err, illegal, state
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS-subset control FSM with memory timeout; ILLEGAL_TRAP_EN adds the TRAP state
module mc_control #(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
`ifdef ILLEGAL_TRAP_EN
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
`else
    S_ADDIWB = 4'd12
`endif
  } state_t;

  // Opcodes are 6-bit codes zero-extended to the IR opcode width
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;
  logic             timeout;

  // State and wait-counter registers; reset returns to IDLE with a clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counter and Moore control decode (FETCH write strobes follow mem_ready)
  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.memread       = 1'b0;
    bus.memwrite      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.memtoreg      = 1'b0;
    bus.regdst        = 1'b0;
    bus.regwrite      = 1'b0;
    bus.alusrc_a      = 1'b0;
    bus.alusrc_b      = 2'b00;
    bus.aluop         = 2'b00;
    bus.pc_source     = 2'b00;
    bus.bus_err       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    bus.illegal       = 1'b0;
`endif
    bus.state         = state_q;

    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready takes priority over an expiring counter
    timeout = wait_st && !bus.mem_ready && (cnt_q == CNT_LAST);
    // Any exit (or refetch) from a wait state leaves the counter at zero for the next entry
    cnt_d   = (wait_st && !bus.mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.memread  = 1'b1;
        bus.alusrc_b = 2'b01;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          bus.bus_err = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.alusrc_b = 2'b11;
        if (bus.opcode == OP_R)                               state_d = S_EXEC;
        else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) state_d = S_MEMADR;
        else if (bus.opcode == OP_BEQ)                        state_d = S_BRANCH;
        else if (bus.opcode == OP_J)                          state_d = S_JUMP;
        else if (bus.opcode == OP_ADDI)                       state_d = S_ADDIEX;
`ifdef ILLEGAL_TRAP_EN
        else                                                  state_d = S_TRAP;
`else
        else                                                  state_d = S_FETCH;
`endif
      end
      S_MEMADR: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = 2'b10;
        state_d      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (timeout) begin
          bus.bus_err = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          bus.bus_err = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.alusrc_a = 1'b1;
        bus.aluop    = 2'b10;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrc_a      = 1'b1;
        bus.aluop         = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = 2'b10;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b11;
        bus.illegal   = 1'b1;
        state_d       = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifndef ILLEGAL_TRAP_EN
  assign bus.illegal = 1'b0;
`endif

endmodule
